rca_config_loader: RTL

Sequencer that drives the write side of the RCA configuration register file. It accepts a stream of 32-bit configuration words over a valid/ready handshake and validates each load header and entry. Each accepted entry becomes exactly one single-cycle write strobe, with address and data, toward the config register file. It sits between the CPU-side configuration path (CSR/DMA feeding words) and the config register file, and raises `busy` so issue logic holds RCA instructions during reconfiguration.

---
 rtl/rca_config_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rca_config_loader.sv
// RCA config loader: turns a header/entry word stream into
// single-cycle write strobes toward the RCA config register file.
module rca_config_loader #(
  parameter int NUM_RCAS           = 4,
  parameter int NUM_READ_PORTS     = 4,
  parameter int NUM_WRITE_PORTS    = 2,
  parameter int GRID_NUM_ROWS      = 4,
  parameter int NUM_GRID_MUXES     = 64,
  parameter int GRID_MUX_INPUTS    = 16,
  parameter int IO_UNIT_MUX_INPUTS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [31:0] cfg_data,
  input  logic cfg_valid,
  output logic cfg_ready,
  output logic [$clog2(NUM_RCAS)-1:0] rca_sel,
  output logic cpu_fb_reg_addr_wr_en,
  output logic cpu_nfb_reg_addr_wr_en,
  output logic cpu_src_dest_port,
  output logic [$clog2(NUM_READ_PORTS)-1:0] cpu_port_sel,
  output logic [4:0] cpu_reg_addr,
  output logic grid_mux_wr_en,
  output logic [$clog2(NUM_GRID_MUXES)-1:0] grid_mux_addr,
  output logic [$clog2(GRID_MUX_INPUTS)-1:0] new_grid_mux_sel,
  output logic io_mux_wr_en,
  output logic [$clog2(GRID_NUM_ROWS)-1:0] io_mux_addr,
  output logic [$clog2(IO_UNIT_MUX_INPUTS)-1:0] new_io_mux_sel,
  output logic rca_result_mux_wr_en,
  output logic [$clog2(NUM_WRITE_PORTS)-1:0] rca_result_mux_addr,
  output logic [$clog2(GRID_NUM_ROWS)-1:0] new_rca_result_mux_sel,
  output logic rca_io_inp_use_wr_en,
  output logic [GRID_NUM_ROWS-1:0] new_rca_io_inp_use,
  output logic busy,
  output logic done,
  output logic error,
  output logic [15:0] entry_count
);

  localparam int RW  = $clog2(NUM_RCAS);
  localparam int PW  = $clog2(NUM_READ_PORTS);
  localparam int GAW = $clog2(NUM_GRID_MUXES);
  localparam int GSW = $clog2(GRID_MUX_INPUTS);
  localparam int IAW = $clog2(GRID_NUM_ROWS);
  localparam int ISW = $clog2(IO_UNIT_MUX_INPUTS);
  localparam int RAW = $clog2(NUM_WRITE_PORTS);
  localparam int RSW = $clog2(GRID_NUM_ROWS);

  typedef enum logic [1:0] {
    IDLE, LOAD, SKIP, DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]  op;
  logic [31:0] addr32;
  logic [31:0] idx32;
  logic is_hdr, hdr_ok, in_rng, acc;
  logic wr_ok, err_set, hdr_take;
  logic unused_bits;

  assign unused_bits = ^cfg_data[15:5];

  assign cfg_ready = (state != DONE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    op     = cfg_data[31:29];
    addr32 = {19'd0, cfg_data[28:16]};
    idx32  = {24'd0, cfg_data[7:0]};
    is_hdr = (cfg_data[31:24] == 8'hC5);
    hdr_ok = is_hdr && (idx32 < NUM_RCAS);
    acc    = cfg_valid && cfg_ready;
    unique case (op)
      3'd0:    in_rng = addr32 < NUM_READ_PORTS;
      3'd1,
      3'd2,
      3'd5:    in_rng = addr32 < NUM_WRITE_PORTS;
      3'd3:    in_rng = addr32 < NUM_GRID_MUXES;
      3'd4:    in_rng = addr32 < GRID_NUM_ROWS;
      default: in_rng = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    wr_ok    = 1'b0;
    err_set  = 1'b0;
    hdr_take = 1'b0;
    unique case (state)
      IDLE: if (acc) begin
        if (hdr_ok) begin
          hdr_take = 1'b1;
          state_nx = LOAD;
        end else begin
          err_set = 1'b1;
        end
      end
      // header words carry op 6, so test magic before treating as IOUSE
      LOAD: if (acc) begin
        if (is_hdr || !in_rng) begin
          err_set  = 1'b1;
          state_nx = SKIP;
        end else if (op == 3'd7) begin
          state_nx = DONE;
        end else begin
          wr_ok = 1'b1;
        end
      end
      SKIP: if (acc && op == 3'd7) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rca_sel                <= '0;
      cpu_fb_reg_addr_wr_en  <= 1'b0;
      cpu_nfb_reg_addr_wr_en <= 1'b0;
      cpu_src_dest_port      <= 1'b0;
      cpu_port_sel           <= '0;
      cpu_reg_addr           <= '0;
      grid_mux_wr_en         <= 1'b0;
      grid_mux_addr          <= '0;
      new_grid_mux_sel       <= '0;
      io_mux_wr_en           <= 1'b0;
      io_mux_addr            <= '0;
      new_io_mux_sel         <= '0;
      rca_result_mux_wr_en   <= 1'b0;
      rca_result_mux_addr    <= '0;
      new_rca_result_mux_sel <= '0;
      rca_io_inp_use_wr_en   <= 1'b0;
      new_rca_io_inp_use     <= '0;
      error                  <= 1'b0;
      entry_count            <= '0;
    end else begin
      cpu_fb_reg_addr_wr_en  <= wr_ok && (op == 3'd0 || op == 3'd1);
      cpu_nfb_reg_addr_wr_en <= wr_ok && (op == 3'd2);
      grid_mux_wr_en         <= wr_ok && (op == 3'd3);
      io_mux_wr_en           <= wr_ok && (op == 3'd4);
      rca_result_mux_wr_en   <= wr_ok && (op == 3'd5);
      rca_io_inp_use_wr_en   <= wr_ok && (op == 3'd6);
      if (hdr_take) rca_sel <= cfg_data[RW-1:0];
      if (wr_ok && op <= 3'd2) begin
        cpu_src_dest_port <= (op != 3'd0);
        cpu_port_sel      <= cfg_data[16 +: PW];
        cpu_reg_addr      <= cfg_data[4:0];
      end
      if (wr_ok && op == 3'd3) begin
        grid_mux_addr    <= cfg_data[16 +: GAW];
        new_grid_mux_sel <= cfg_data[0 +: GSW];
      end
      if (wr_ok && op == 3'd4) begin
        io_mux_addr    <= cfg_data[16 +: IAW];
        new_io_mux_sel <= cfg_data[0 +: ISW];
      end
      if (wr_ok && op == 3'd5) begin
        rca_result_mux_addr    <= cfg_data[16 +: RAW];
        new_rca_result_mux_sel <= cfg_data[0 +: RSW];
      end
      if (wr_ok && op == 3'd6)
        new_rca_io_inp_use <= cfg_data[GRID_NUM_ROWS-1:0];
      if (hdr_take)     error <= 1'b0;
      else if (err_set) error <= 1'b1;
      if (hdr_take)
        entry_count <= '0;
      else if (wr_ok && entry_count != 16'hFFFF)
        entry_count <= entry_count + 16'd1;
    end
  end

endmodule
